// File: rtl/nanorv32_muldiv_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response handshakes.
// Multiply is shift-add over magnitudes, divide is restoring over magnitudes; a final FIX
// cycle applies the sign and selects the result word. Divide-by-zero and signed overflow
// bypass the iteration and complete straight from IDLE.
module nanorv32_muldiv_iter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MUL_STEP = 4,
    parameter int unsigned DIV_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              busy
);

    localparam int unsigned MulCyc = DATA_W / MUL_STEP;
    localparam int unsigned DivCyc = DATA_W / DIV_STEP;
    localparam int unsigned CntW   = $clog2(DATA_W + 1);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     mcand_q, mcand_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     result_q, result_d;

    logic                  sa, sb, signed_a, signed_b;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic                  div_zero, div_ovf, fast;
    logic [DATA_W-1:0]     fast_result;
    logic [MUL_STEP-1:0]   mul_digit;
    logic [DATA_W+MUL_STEP-1:0] mul_pp, mul_sum;
    logic [2*DATA_W-1:0]   mul_next, div_next, prod;
    logic [DATA_W:0]       div_r, div_t;
    logic [DATA_W-1:0]     div_q, quo, rem, fix_result;

    assign req_ready   = (state_q == StIdle) && !flush;
    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign busy        = (state_q != StIdle);

    // Operand decode at accept: signedness, magnitudes and the RISC-V corner cases.
    always_comb begin
        signed_a = (req_op != OpMulhu) && (req_op != OpDivu) && (req_op != OpRemu);
        signed_b = signed_a && (req_op != OpMulhsu);
        sa       = signed_a & req_a[DATA_W-1];
        sb       = signed_b & req_b[DATA_W-1];
        abs_a    = sa ? -req_a : req_a;
        abs_b    = sb ? -req_b : req_b;
        div_zero = (req_b == '0);
        div_ovf  = ((req_op == OpDiv) || (req_op == OpRem)) &&
                   (req_a == {1'b1, {(DATA_W-1){1'b0}}}) && (req_b == '1);
        fast     = req_op[2] && (div_zero || div_ovf);
        if (div_zero) begin
            fast_result = req_op[1] ? req_a : '1;
        end else begin
            fast_result = req_op[1] ? '0 : req_a;
        end
    end

    // One multiply step: add mcand * low digit into the high half, shift right by a digit.
    always_comb begin
        mul_digit = acc_q[MUL_STEP-1:0];
        mul_pp    = {{MUL_STEP{1'b0}}, mcand_q} * {{DATA_W{1'b0}}, mul_digit};
        mul_sum   = {{MUL_STEP{1'b0}}, acc_q[2*DATA_W-1:DATA_W]} + mul_pp;
        mul_next  = (2*DATA_W)'({mul_sum, acc_q[DATA_W-1:0]} >> MUL_STEP);
    end

    // DIV_STEP restoring-division steps: acc holds {partial remainder, dividend/quotient}.
    always_comb begin
        div_r = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        div_q = acc_q[DATA_W-1:0];
        div_t = '0;
        for (int i = 0; i < int'(DIV_STEP); i++) begin
            div_r = {div_r[DATA_W-1:0], div_q[DATA_W-1]};
            div_q = {div_q[DATA_W-2:0], 1'b0};
            div_t = div_r - {1'b0, mcand_q};
            if (!div_t[DATA_W]) begin
                div_r    = div_t;
                div_q[0] = 1'b1;
            end
        end
        div_next = {div_r[DATA_W-1:0], div_q};
    end

    // Sign fix-up and result word selection.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[DATA_W-1:0];
        rem  = acc_q[2*DATA_W-1:DATA_W];
        case (op_q)
            OpMul:          fix_result = prod[DATA_W-1:0];
            OpDiv, OpDivu:  fix_result = neg_q ? -quo : quo;
            OpRem, OpRemu:  fix_result = neg_q ? -rem : rem;
            default:        fix_result = prod[2*DATA_W-1:DATA_W];
        endcase
    end

    // Next-state logic; flush overrides everything and drops any pending response.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        neg_d        = neg_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    op_d  = req_op;
                    // Remainder follows the dividend; everything else follows sa ^ sb.
                    neg_d = (req_op[2] && req_op[1]) ? sa : (sa ^ sb);
                    cnt_d = req_op[2] ? CntW'(DivCyc - 1) : CntW'(MulCyc - 1);
                    if (fast) begin
                        result_d     = fast_result;
                        resp_valid_d = 1'b1;
                        state_d      = StDone;
                    end else begin
                        acc_d   = req_op[2] ? {{DATA_W{1'b0}}, abs_a} : {{DATA_W{1'b0}}, abs_b};
                        mcand_d = req_op[2] ? abs_b : abs_a;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                result_d     = fix_result;
                resp_valid_d = 1'b1;
                state_d      = StDone;
            end
            StDone: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d      = StIdle;
            resp_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= OpMul;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_muldiv_iter.sv
// Directed bench for nanorv32_muldiv_iter: default 32-bit instance plus a 16-bit instance
// with MUL_STEP=8, DIV_STEP=2. Latency is counted in clock edges after the accept edge.
module tb_nanorv32_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid32 = 1'b0, req_ready32, flush32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0, result32;
    logic        resp_valid32, resp_ready32 = 1'b0, busy32;

    logic        req_valid16 = 1'b0, req_ready16, flush16 = 1'b0;
    logic [2:0]  op16 = 3'd0;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic        resp_valid16, resp_ready16 = 1'b0, busy16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nanorv32_muldiv_iter dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid32), .req_ready(req_ready32),
        .req_op(op32), .req_a(a32), .req_b(b32), .flush(flush32),
        .resp_valid(resp_valid32), .resp_ready(resp_ready32), .resp_result(result32),
        .busy(busy32)
    );

    nanorv32_muldiv_iter #(.DATA_W(16), .MUL_STEP(8), .DIV_STEP(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid16), .req_ready(req_ready16),
        .req_op(op16), .req_a(a16), .req_b(b16), .flush(flush16),
        .resp_valid(resp_valid16), .resp_ready(resp_ready16), .resp_result(result16),
        .busy(busy16)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request; returns once resp_valid is seen or the budget runs out.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; req_valid32 = 1'b1;
        @(posedge clk);
        #1;
        req_valid32 = 1'b0;
        a32 = 32'hDEAD_BEEF;  // operands must only matter at accept
        b32 = 32'h1357_9BDF;
        lat = 0;
        while (!resp_valid32 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result32;
    endtask

    task automatic retire32();
        resp_ready32 = 1'b1;
        @(posedge clk);
        #1;
        resp_ready32 = 1'b0;
        check_eq("retire_rv_low", 64'(resp_valid32), 64'd0);
        check_eq("retire_req_ready", 64'(req_ready32), 64'd1);
    endtask

    task automatic op32_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        issue32(op, a, b, res, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq(tag, 64'(res), 64'(exp));
        retire32();
    endtask

    task automatic op16_chk(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; req_valid16 = 1'b1;
        @(posedge clk);
        #1;
        req_valid16 = 1'b0;
        a16 = 16'hBEEF;
        lat = 0;
        while (!resp_valid16 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq(tag, 64'(result16), 64'(exp));
        resp_ready16 = 1'b1;
        @(posedge clk);
        #1;
        resp_ready16 = 1'b0;
        check_eq({tag, "_rv_low"}, 64'(resp_valid16), 64'd0);
    endtask

    initial begin
        logic [31:0] res, held;
        int          lat, seen;

        // Reset values, including combinational req_ready during reset.
        #2;
        check_eq("rst_req_ready", 64'(req_ready32), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid32), 64'd0);
        check_eq("rst_busy", 64'(busy32), 64'd0);
        check_eq("rst_result", 64'(result32), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Multiply: STEPS = 32/4 = 8, so valid 9 edges after accept.
        op32_chk("mul",    3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 9);
        op32_chk("mulh",   3'd1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 9);
        op32_chk("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
        op32_chk("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);

        // Divide: STEPS = 32, valid 33 edges after accept.
        op32_chk("div",  3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        op32_chk("rem",  3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        op32_chk("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        op32_chk("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        op32_chk("div_pos_neg", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        op32_chk("rem_pos_neg", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        // Fast paths: valid already in the cycle right after the accept edge.
        op32_chk("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        op32_chk("rem_by0",  3'd6, 32'd5, 32'd0, 32'd5, 0);
        op32_chk("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        op32_chk("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // Backpressure: result held, no new accept while the consumer stalls.
        issue32(3'd0, 32'd6, 32'd7, held, lat);
        check_eq("bp_result", 64'(held), 64'd42);
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_result", 64'(result32), 64'(held));
            check_eq("bp_hold_valid", 64'(resp_valid32), 64'd1);
            check_eq("bp_req_ready", 64'(req_ready32), 64'd0);
        end
        retire32();

        // Flush during CALC cycle 10: back to IDLE, no response ever.
        @(negedge clk);
        op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3; req_valid32 = 1'b1;
        @(posedge clk);
        #1;
        req_valid32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush32 = 1'b1;
        #1;
        check_eq("flush_req_ready", 64'(req_ready32), 64'd0);
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        check_eq("flush_busy", 64'(busy32), 64'd0);
        check_eq("flush_rv", 64'(resp_valid32), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid32) seen++;
        end
        check_eq("flush_no_resp", 64'(seen), 64'd0);

        // Request presented together with flush in IDLE is not taken.
        @(negedge clk);
        flush32 = 1'b1; op32 = 3'd5; a32 = 32'd9; b32 = 32'd0; req_valid32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0; req_valid32 = 1'b0;
        check_eq("flush_idle_busy", 64'(busy32), 64'd0);
        check_eq("flush_idle_rv", 64'(resp_valid32), 64'd0);
        op32_chk("after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3; req_valid32 = 1'b1;
        @(posedge clk);
        #1;
        req_valid32 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy32), 64'd0);
        check_eq("arst_rv", 64'(resp_valid32), 64'd0);
        check_eq("arst_result", 64'(result32), 64'd0);
        check_eq("arst_req_ready", 64'(req_ready32), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid32) seen++;
        end
        check_eq("arst_no_resp", 64'(seen), 64'd0);
        check_eq("arst_result_after", 64'(result32), 64'd0);
        op32_chk("after_rst", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);

        // 16-bit instance: divide 16/2 = 8 steps, multiply 16/8 = 2 steps.
        op16_chk("w16_divu",  3'd5, 16'hFFFF, 16'h0003, 16'h5555, 9);
        op16_chk("w16_mulhu", 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3);
        op16_chk("w16_mul",   3'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 3);
        op16_chk("w16_rem",   3'd6, 16'hFFF9, 16'h0002, 16'hFFFF, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nanorv32_muldiv_iter.md
Name: nanorv32_muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the RV32M instructions. It succeeds the single-cycle multiplier and the fixed-width divider inside the ALU. Width and bits-per-cycle are configurable for multiply and divide independently. It adds a valid/ready request and response handshake, RISC-V corner-case fast paths, and a pipeline flush. It sits beside the ALU and is driven by the execute stage; the result is held until the pipeline accepts it.

Parameters:
DATA_W, 32, operand/result width; must be even, >= 8.
MUL_STEP, 4, multiplier bits retired per CALC cycle; must divide DATA_W (1, 2, 4 or 8).
DIV_STEP, 1, quotient bits retired per CALC cycle; must divide DATA_W (1, 2 or 4).

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
req_a  in  DATA_W  operand rs1.
req_b  in  DATA_W  operand rs2.
flush  in  1  abort the in-flight operation; discard its result.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes the result.
resp_result  out  DATA_W  result.
busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, resp_valid 0, resp_result 0, busy 0. req_ready is combinational and reads 1 while in reset.
- Acceptance: req_ready = (state==IDLE) & ~flush. A request is accepted on the edge where req_valid & req_ready. At that edge op, operand signs and absolute values are latched, and the step counter is loaded.
- State machine:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a fast-path accept.
  - CALC -> FIX when the counter reaches its terminal count.
  - FIX -> DONE.
  - DONE -> IDLE on resp_ready.
- Signedness: MUL, MULH, DIV and REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU, DIVU and REMU are unsigned. MUL low word is identical for all signedness.
- CALC for multiply: shift-add of MUL_STEP multiplier bits per cycle into a 2*DATA_W accumulator. Runs DATA_W/MUL_STEP cycles.
- CALC for divide: restoring division, DIV_STEP quotient bits per cycle. Runs DATA_W/DIV_STEP cycles.
- FIX: conditional two's-complement negation. Product sign = sa ^ sb. Quotient sign = sa ^ sb. Remainder takes the dividend's sign. FIX then selects the low word (MUL), the high word (MULH*), the quotient or the remainder.
- Latency: resp_valid rises STEPS+1 edges after the accept edge, where STEPS = DATA_W/STEP. Defaults: multiply 9 cycles, divide 33 cycles.
- Fast path, resp_valid one edge after accept:
  - Divisor 0: DIV and DIVU return all ones; REM and REMU return the dividend.
  - Signed overflow (DIV/REM with a = most-negative, b = -1): DIV returns most-negative; REM returns 0.
- Response: resp_valid and resp_result are held stable while resp_valid & ~resp_ready. resp_valid clears on the resp_ready edge.
- Throughput: the next request can be accepted one cycle after the response handshake, since req_ready is not combinational on resp_ready.
- Flush:
  - Any state goes to IDLE on the next edge and resp_valid clears; no response is produced for the aborted op.
  - flush with req_valid in IDLE: the request is not accepted.
  - flush in DONE together with resp_ready: the result is dropped; the consumer must ignore it.
- Reset mid-operation: the unit returns immediately to its reset values; no stale result may appear after rst_n deasserts.
- Operands req_a and req_b are sampled only at accept and may change afterwards.

Test Plan:
- MUL 0x12345678 x 0x00000010, defaults -> resp_result 0x23456780 with resp_valid 9 cycles after accept. MULH 0xFFFFFFF9 (-7) x 3 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each result appears 33 cycles after accept.
- Fast paths, each with resp_valid one cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold resp_ready low 5 cycles after resp_valid -> resp_result constant, req_ready 0 throughout. Raise resp_ready -> resp_valid low next edge, req_ready high.
- Flush and reset: DIV with flush at CALC cycle 10 -> IDLE next edge, no resp_valid ever. A new request is then accepted and correct. Repeat with rst_n pulsed mid-CALC -> all outputs at reset values.
- DATA_W=16, DIV_STEP=2, MUL_STEP=8: DIVU 0xFFFF/0x0003 -> 0x5555 at 9 cycles; MULHU 0xFFFF x 0xFFFF -> 0xFFFE at 3 cycles.
